// File: rtl/mem_port_arbiter_if.sv
// Request/grant bundle between the eight requesters and the shared 64-bit port arbiter.
interface mem_port_arbiter_if;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       busy;
   logic       timeout;

   modport slave  (input req, done, output gnt, sel, busy, timeout);
   modport master (output req, done, input gnt, sel, busy, timeout);
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting one of eight requesters exclusive use of a shared 64-bit port.
// Define ARB_TIMEOUT_EN to force release of a grant held for TIMEOUT cycles without done.
module mem_port_arbiter #(
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t     r_state;
   logic [2:0] r_ptr;
   logic [2:0] r_sel;
   logic [7:0] r_gnt;
   logic       r_busy;
   logic       r_timeout;

   logic       w_anyReq;
   logic       w_expire;
   logic       w_release;
   logic [2:0] w_base;
   logic [2:0] w_winner;

   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_badTimeout
      $error("mem_port_arbiter: TIMEOUT out of range 1..65535");
   end

`ifdef ARB_TIMEOUT_EN
   logic [15:0] r_holdCnt;

   // Expiry fires on the edge that completes the TIMEOUT-th cycle of a grant.
   assign w_expire = (r_state == GRANT) && (r_holdCnt == 16'(TIMEOUT - 1));
`else
   assign w_expire = 1'b0;
`endif

   assign w_anyReq  = |bus.req;
   assign w_release = bus.done || w_expire;

   // A releasing grant arbitrates from the slot after the owner so back-to-back grants rotate fairly.
   assign w_base = (r_state == GRANT) ? (r_sel + 3'd1) : r_ptr;

   always_comb begin
      w_winner = w_base;
      for (int j = 7; j >= 0; j--) begin
         if (bus.req[w_base + 3'(j)]) begin
            w_winner = w_base + 3'(j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ptr     <= 3'd0;
         r_sel     <= 3'd0;
         r_gnt     <= 8'd0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_holdCnt <= 16'd0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_timeout <= 1'b0;
               if (w_anyReq) begin
                  r_state <= GRANT;
                  r_gnt   <= 8'd1 << w_winner;
                  r_sel   <= w_winner;
                  r_busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                  r_holdCnt <= 16'd0;
`endif
               end
            end
            GRANT: begin
               // Simultaneous done and expiry is an ordinary completion, so no timeout pulse.
               r_timeout <= w_expire && !bus.done;
               if (w_release) begin
                  r_ptr <= r_sel + 3'd1;
                  if (w_anyReq) begin
                     r_gnt <= 8'd1 << w_winner;
                     r_sel <= w_winner;
`ifdef ARB_TIMEOUT_EN
                     r_holdCnt <= 16'd0;
`endif
                  end else begin
                     r_state <= IDLE;
                     r_gnt   <= 8'd0;
                     r_busy  <= 1'b0;
                  end
               end else begin
`ifdef ARB_TIMEOUT_EN
                  r_holdCnt <= r_holdCnt + 16'd1;
`endif
               end
            end
            default: begin
               r_state <= IDLE;
               r_gnt   <= 8'd0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.sel     = r_sel;
   assign bus.busy    = r_busy;
   assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a round-robin reference model.
module tb_mem_port_arbiter;

   localparam int TB_TIMEOUT = 4;

   logic clk = 1'b0;
   logic rst;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int testCount = 0;
   int failCount = 0;

   // Reference model: who owns the port, where the rotation resumes, how long the owner has held it.
   bit mGranted;
   int mOwner;
   int mPtr;
   int mSel;
   int mHold;
   bit mTout;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int pickFrom(input int start, input logic [7:0] r);
      for (int k = 0; k < 8; k++) begin
         if (r[(start + k) % 8]) return (start + k) % 8;
      end
      return -1;
   endfunction

   task automatic modelUpdate(input bit r, input logic [7:0] rq, input bit d);
      bit expire;
      if (r) begin
         mGranted = 0; mSel = 0; mPtr = 0; mHold = 0; mTout = 0; mOwner = 0;
         return;
      end
      mTout = 0;
      if (!mGranted) begin
         if (rq != 0) begin
            mOwner = pickFrom(mPtr, rq); mSel = mOwner; mGranted = 1; mHold = 0;
         end
      end else begin
         expire = 0;
`ifdef ARB_TIMEOUT_EN
         expire = (mHold + 1 >= TB_TIMEOUT);
`endif
         if (d || expire) begin
            mTout = expire && !d;
            mPtr  = (mOwner + 1) % 8;
            if (rq != 0) begin
               mOwner = pickFrom(mPtr, rq); mSel = mOwner; mHold = 0;
            end else begin
               mGranted = 0;
            end
         end else begin
            mHold++;
         end
      end
   endtask

   // Drive one cycle of inputs, advance DUT and model across the edge, then compare just after it.
   task automatic applyStimulus(input bit r, input logic [7:0] rq, input bit d);
      logic [7:0] expGnt;
      rst      = r;
      bus.req  = rq;
      bus.done = d;
      @(posedge clk);
      modelUpdate(r, rq, d);
      #1;
      expGnt = mGranted ? (8'd1 << mOwner) : 8'd0;
      checkOutput("gnt", 32'(bus.gnt), 32'(expGnt));
      checkOutput("sel", 32'(bus.sel), 32'(mSel));
      checkOutput("busy", 32'(bus.busy), 32'(mGranted));
      checkOutput("timeout", 32'(bus.timeout), 32'(mTout));
   endtask

   initial begin
      logic [7:0] rq;
      rst      = 1'b1;
      bus.req  = 8'd0;
      bus.done = 1'b0;
      mGranted = 0; mOwner = 0; mPtr = 0; mSel = 0; mHold = 0; mTout = 0;
      #2;

      // Single requester grant and release
      applyStimulus(1, 8'hA5, 1);
      checkOutput("rst_gnt", 32'(bus.gnt), 32'h0);
      applyStimulus(0, 8'h01, 0);
      checkOutput("r029_gnt", 32'(bus.gnt), 32'h01);
      checkOutput("r029_busy", 32'(bus.busy), 32'h1);
      applyStimulus(0, 8'h00, 1);
      checkOutput("r029_idle", 32'(bus.gnt), 32'h0);
      checkOutput("r029_selHold", 32'(bus.sel), 32'h0);
      applyStimulus(0, 8'h00, 1);

      // Full rotation with everybody requesting
      applyStimulus(1, 8'h00, 0);
      applyStimulus(0, 8'hFF, 0);
      for (int g = 0; g < 9; g++) begin
         checkOutput("r030_sel", 32'(bus.sel), 32'(g % 8));
         checkOutput("r030_busy", 32'(bus.busy), 32'h1);
         applyStimulus(0, 8'hFF, 0);
         applyStimulus(0, 8'hFF, 0);
         applyStimulus(0, 8'hFF, 1);
      end

      // Grant survives request drop
      applyStimulus(1, 8'h00, 0);
      applyStimulus(0, 8'h04, 0);
      applyStimulus(0, 8'h20, 0);
      applyStimulus(0, 8'h20, 0);
      checkOutput("r031_hold", 32'(bus.gnt), 32'h04);
      applyStimulus(0, 8'h20, 1);
      checkOutput("r031_next", 32'(bus.gnt), 32'h20);

      // Pointer wrap from 7
      applyStimulus(1, 8'h00, 0);
      applyStimulus(0, 8'h80, 0);
      checkOutput("r032_own7", 32'(bus.gnt), 32'h80);
      applyStimulus(0, 8'h81, 1);
      checkOutput("r032_wrap", 32'(bus.gnt), 32'h01);

      // Reset mid-transaction, late done ignored
      applyStimulus(1, 8'h00, 0);
      applyStimulus(0, 8'h08, 0);
      checkOutput("r033_own3", 32'(bus.sel), 32'h3);
      applyStimulus(1, 8'h08, 0);
      checkOutput("r033_rstGnt", 32'(bus.gnt), 32'h0);
      checkOutput("r033_rstSel", 32'(bus.sel), 32'h0);
      applyStimulus(0, 8'h00, 1);
      checkOutput("r033_doneIgn", 32'(bus.busy), 32'h0);

      // Held grant with no done
      applyStimulus(1, 8'h00, 0);
      applyStimulus(0, 8'h06, 0);
      checkOutput("r034_first", 32'(bus.gnt), 32'h02);
`ifdef ARB_TIMEOUT_EN
      for (int c = 0; c < 3; c++) applyStimulus(0, 8'h06, 0);
      checkOutput("r034_stillOwn", 32'(bus.gnt), 32'h02);
      applyStimulus(0, 8'h06, 0);
      checkOutput("r034_moved", 32'(bus.gnt), 32'h04);
      checkOutput("r034_pulse", 32'(bus.timeout), 32'h1);
      applyStimulus(0, 8'h06, 0);
      checkOutput("r034_pulseEnd", 32'(bus.timeout), 32'h0);
`else
      for (int c = 0; c < 12; c++) applyStimulus(0, 8'h06, 0);
      checkOutput("r034_persist", 32'(bus.gnt), 32'h02);
      checkOutput("r034_noPulse", 32'(bus.timeout), 32'h0);
`endif

      // Randomized traffic
      applyStimulus(1, 8'h00, 0);
      for (int n = 0; n < 3000; n++) begin
         rq = 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 7) == 0) rq = 8'h00;
         applyStimulus(($urandom_range(0, 99) == 0), rq, ($urandom_range(0, 2) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
